popcount_accumulator: RTL and testbench

//   Streaming consumer of bit_counter. Accepts a frame of 32-bit words over a

---
 rtl/popcount_accumulator.sv | 129 ++++++++++++
 tb/tb_popcount_accumulator.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_accumulator.sv
// Frame popcount accumulator: counts set bits of each accepted 32-bit word,
// sums them over a frame (saturating) and hands the frame total, word count
// and saturation flag to a valid/ready sink.

module bit_counter (
  input  logic [31:0] data,
  output logic [5:0]  count
);

  // Sum the individual bits of the word (result 0..32)
  always_comb begin
    count = '0;
    for (int i = 0; i < 32; i++) begin
      count = count + 6'(data[i]);
    end
  end

endmodule

module popcount_accumulator #(
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_total,
  output logic [CNT_WIDTH-1:0] out_words,
  output logic                 out_sat
);

  typedef enum logic {RUN, DONE} state_t;

  state_t               state;
  logic [5:0]           pc;
  logic [5:0]           s1_pc;
  logic                 s1_valid;
  logic                 s1_last;
  logic                 accept;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [CNT_WIDTH-1:0] words;
  logic [CNT_WIDTH-1:0] words_next;
  logic                 sat;
  logic                 sat_next;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [CNT_WIDTH:0]   words_sum;

  bit_counter u_bit_counter (
    .data  (in_data),
    .count (pc)
  );

  // in_ready depends only on registers, so out_ready never reaches it combinationally
  assign in_ready = (state == RUN) && !(s1_valid && s1_last);
  assign accept   = in_valid && in_ready;

  // Stage 1: capture the word's bit count and frame marker on every accepted beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_pc    <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_pc   <= pc;
        s1_last <= in_last;
      end
    end
  end

  // Saturating adds for the running total and word count; overflow sets sticky sat
  always_comb begin
    acc_sum    = {1'b0, acc} + (ACC_WIDTH+1)'(s1_pc);
    words_sum  = {1'b0, words} + (CNT_WIDTH+1)'(1);
    acc_next   = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
    words_next = words_sum[CNT_WIDTH] ? '1 : words_sum[CNT_WIDTH-1:0];
    sat_next   = sat | acc_sum[ACC_WIDTH] | words_sum[CNT_WIDTH];
  end

  // Stage 2 and result FSM: accumulate, publish on the last beat, wait for the sink
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      acc       <= '0;
      words     <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_total <= '0;
      out_words <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (s1_valid) begin
            if (s1_last) begin
              out_total <= acc_next;
              out_words <= words_next;
              out_sat   <= sat_next;
              out_valid <= 1'b1;
              acc       <= '0;
              words     <= '0;
              sat       <= 1'b0;
              state     <= DONE;
            end else begin
              acc   <= acc_next;
              words <= words_next;
              sat   <= sat_next;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_accumulator.sv
// Testbench for popcount_accumulator: two instances (16-bit and 8-bit
// accumulators) share one stimulus stream; expected results are queued per
// instance and popped by independent monitors on each result handshake.

module tb_popcount_accumulator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready16, out_valid16, out_sat16;
  logic [15:0] out_total16;
  logic [11:0] out_words16;
  logic        in_ready8, out_valid8, out_sat8;
  logic [7:0]  out_total8;
  logic [11:0] out_words8;

  typedef struct {
    longint total;
    longint words;
    longint sat;
  } result_t;

  result_t exp16[$];
  result_t exp8[$];
  int      checks = 0;
  int      fails = 0;
  int      readyMode = 0;

  always #5 clk = ~clk;

  popcount_accumulator #(.ACC_WIDTH(16), .CNT_WIDTH(12)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid16),
    .out_ready(out_ready), .out_total(out_total16), .out_words(out_words16),
    .out_sat(out_sat16)
  );

  popcount_accumulator #(.ACC_WIDTH(8), .CNT_WIDTH(12)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid8),
    .out_ready(out_ready), .out_total(out_total8), .out_words(out_words8),
    .out_sat(out_sat8)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: count ones over the whole frame, then clamp to the field widths
  function automatic result_t modelFrame(input int unsigned frame[$], input int accW, input int cntW);
    result_t r;
    longint  sum = 0;
    longint  n = frame.size();
    longint  maxA = (longint'(1) << accW) - 1;
    longint  maxC = (longint'(1) << cntW) - 1;
    foreach (frame[i]) begin
      for (int b = 0; b < 32; b++) sum += (frame[i] >> b) & 1;
    end
    r.total = (sum > maxA) ? maxA : sum;
    r.words = (n > maxC) ? maxC : n;
    r.sat   = ((sum > maxA) || (n > maxC)) ? 1 : 0;
    return r;
  endfunction

  // Sink readiness is changed shortly after each rising edge
  always @(posedge clk) begin
    #2;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor for the 16-bit instance
  always @(negedge clk) begin
    if (reset_n && out_valid16 && out_ready) begin
      if (exp16.size() == 0) begin
        checkOutput("unexpected_result16", exp16.size(), 1);
      end else begin
        result_t e;
        e = exp16.pop_front();
        checkOutput("total16", out_total16, e.total);
        checkOutput("words16", out_words16, e.words);
        checkOutput("sat16", out_sat16, e.sat);
      end
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (reset_n && out_valid8 && out_ready) begin
      if (exp8.size() == 0) begin
        checkOutput("unexpected_result8", exp8.size(), 1);
      end else begin
        result_t e;
        e = exp8.pop_front();
        checkOutput("total8", out_total8, e.total);
        checkOutput("words8", out_words8, e.words);
        checkOutput("sat8", out_sat8, e.sat);
      end
    end
  end

  task automatic driveBeat(input int unsigned data, input logic last, input int gapPct, inout int stalls);
    int t;
    @(negedge clk);
    if (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      in_last  = 1'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    t = 0;
    while (!in_ready16 && t < 2000) begin
      stalls++;
      t++;
      @(negedge clk);
    end
    if (t >= 2000) checkOutput("in_ready_timeout", in_ready16, 1);
    @(posedge clk);
  endtask

  task automatic applyStimulus(input int unsigned frame[$], input int gapPct, output int stalls);
    stalls = 0;
    exp16.push_back(modelFrame(frame, 16, 12));
    exp8.push_back(modelFrame(frame, 8, 12));
    foreach (frame[i]) driveBeat(frame[i], (i == frame.size() - 1), gapPct, stalls);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic waitDrain();
    int t = 0;
    while ((exp16.size() != 0 || exp8.size() != 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("drain16", exp16.size(), 0);
    checkOutput("drain8", exp8.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int unsigned frame[$];
    int stalls;
    int t;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", out_valid16, 0);
    checkOutput("reset_out_total", out_total16, 0);
    checkOutput("reset_out_words", out_words16, 0);
    checkOutput("reset_out_sat", out_sat16, 0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready16, 1);

    // Single full word, with latency checks
    frame = '{32'hFFFF_FFFF};
    applyStimulus(frame, 0, stalls);
    checkOutput("t1_out_valid", out_valid16, 0);
    checkOutput("t1_in_ready", in_ready16, 0);
    @(negedge clk);
    checkOutput("t2_out_valid", out_valid16, 1);
    checkOutput("t2_in_ready", in_ready16, 0);
    checkOutput("t2_total", out_total16, 32);
    @(negedge clk);
    checkOutput("t3_in_ready", in_ready16, 1);
    waitDrain();

    // Back-to-back four-word frame
    frame = '{32'h0, 32'h1, 32'h8000_0001, 32'hF0F0_F0F0};
    applyStimulus(frame, 0, stalls);
    checkOutput("b2b_stalls", stalls, 0);
    waitDrain();

    // Same frame with the sink stalled
    readyMode = 2;
    applyStimulus(frame, 0, stalls);
    t = 0;
    while (!out_valid16 && t < 100) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_out_valid", out_valid16, 1);
      checkOutput("stall_total", out_total16, 19);
      checkOutput("stall_words", out_words16, 4);
      checkOutput("stall_in_ready", in_ready16, 0);
    end
    readyMode = 0;
    waitDrain();
    frame = '{32'hFF, 32'h1};
    applyStimulus(frame, 0, stalls);
    waitDrain();

    // Nine full words saturate the 8-bit total; next frame starts clean
    frame = {};
    repeat (9) frame.push_back(32'hFFFF_FFFF);
    applyStimulus(frame, 0, stalls);
    frame = '{32'h3};
    applyStimulus(frame, 0, stalls);
    waitDrain();

    // Word counter saturation
    frame = {};
    repeat (4100) frame.push_back(32'h1);
    applyStimulus(frame, 0, stalls);
    waitDrain();

    // Reset in the middle of a frame discards it
    stalls = 0;
    driveBeat(32'hFFFF_0000, 1'b0, 0, stalls);
    driveBeat(32'h0000_FFFF, 1'b0, 0, stalls);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid16, 0);
    checkOutput("midreset_out_words", out_words16, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset_in_ready", in_ready16, 1);
    frame = '{32'h7};
    applyStimulus(frame, 0, stalls);
    waitDrain();

    // Random frames with source gaps and sink back-pressure
    readyMode = 1;
    for (int f = 0; f < 1000; f++) begin
      int len;
      frame = {};
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0:       frame.push_back(32'hFFFF_FFFF);
          1:       frame.push_back(32'h0);
          default: frame.push_back($urandom);
        endcase
      end
      applyStimulus(frame, 30, stalls);
    end
    readyMode = 0;
    waitDrain();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
